// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller:
// FSM encoding, forwarding-source codes and the stage scoreboard entry.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        LOAD_STALL = 2'b01,
        MEM_WAIT   = 2'b10
    } ctrl_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    localparam logic [3:0] REG_PC = 4'd15;

    // Destination tracking for one downstream pipeline stage.
    typedef struct packed {
        logic       valid;
        logic [3:0] rd;
        logic       load;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '{valid: 1'b0, rd: 4'd0, load: 1'b0};

endpackage

// File: rtl/fwd_select.sv
// Forwarding source selection for one ID-stage operand against the
// EX/MEM/WB scoreboard; the youngest matching producer wins.
module fwd_select
    import pipe_ctrl_pkg::*;
(
    input  logic       use_reg,
    input  logic [3:0] src,
    input  sb_entry_t  ex_e,
    input  sb_entry_t  mem_e,
    input  sb_entry_t  wb_e,
    output logic [1:0] fwd
);

    // NOTE: fwd gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        fwd = FWD_RF;
        if (use_reg && src != REG_PC) begin
            if (ex_e.valid && ex_e.rd == src) begin
                fwd = FWD_EX;
            end else if (mem_e.valid && mem_e.rd == src) begin
                fwd = FWD_MEM;
            end else if (wb_e.valid && wb_e.rd == src) begin
                fwd = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller: operand forwarding, load-use stalls, branch
// flushes and data-memory wait freezes with timeout for the 5-stage pipeline.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [3:0]       id_rn,
    input  logic [3:0]       id_rm,
    input  logic [3:0]       id_rd,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic             id_use_rd,
    input  logic             id_rf_en,
    input  logic             id_load,
    input  logic             id_branch_taken,
    input  logic             mem_access,
    input  logic             mem_ready,
    output logic             pc_le,
    output logic             ifid_le,
    output logic             ifid_clr,
    output logic             nop_sel,
    output logic             pipe_freeze,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       fwd_c,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    ctrl_state_e      state_q, state_d;
    sb_entry_t        ex_q, mem_q, wb_q;
    sb_entry_t        ex_d, mem_d, wb_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [1:0] fwd_a_raw, fwd_b_raw, fwd_c_raw;
    logic       mem_wait_req;
    logic       load_use;

    fwd_select u_fwd_a (
        .use_reg (id_use_rn),
        .src     (id_rn),
        .ex_e    (ex_q),
        .mem_e   (mem_q),
        .wb_e    (wb_q),
        .fwd     (fwd_a_raw)
    );

    fwd_select u_fwd_b (
        .use_reg (id_use_rm),
        .src     (id_rm),
        .ex_e    (ex_q),
        .mem_e   (mem_q),
        .wb_e    (wb_q),
        .fwd     (fwd_b_raw)
    );

    fwd_select u_fwd_c (
        .use_reg (id_use_rd),
        .src     (id_rd),
        .ex_e    (ex_q),
        .mem_e   (mem_q),
        .wb_e    (wb_q),
        .fwd     (fwd_c_raw)
    );

    assign mem_wait_req = mem_access & ~mem_ready;

    // A load in EX cannot forward yet: any consumer reading its rd must wait a cycle.
    assign load_use = ex_q.valid && ex_q.load &&
                      ((id_use_rn && id_rn == ex_q.rd) ||
                       (id_use_rm && id_rm == ex_q.rd) ||
                       (id_use_rd && id_rd == ex_q.rd));

    always_comb begin
        state_d     = state_q;
        to_cnt_d    = to_cnt_q;
        pc_le       = 1'b1;
        ifid_le     = 1'b1;
        ifid_clr    = 1'b0;
        nop_sel     = 1'b0;
        pipe_freeze = 1'b0;
        mem_err     = 1'b0;

        unique case (state_q)
            RUN: begin
                if (mem_wait_req) begin
                    pipe_freeze = 1'b1;
                    pc_le       = 1'b0;
                    ifid_le     = 1'b0;
                    state_d     = MEM_WAIT;
                    to_cnt_d    = '0;
                end else if (load_use) begin
                    pc_le   = 1'b0;
                    ifid_le = 1'b0;
                    nop_sel = 1'b1;
                    state_d = LOAD_STALL;
                end else if (id_branch_taken) begin
                    ifid_clr = 1'b1;
                end
            end
            LOAD_STALL: begin
                // The held consumer now forwards from MEM; a blocked branch resolves here.
                state_d = RUN;
                if (mem_wait_req) begin
                    pipe_freeze = 1'b1;
                    pc_le       = 1'b0;
                    ifid_le     = 1'b0;
                    state_d     = MEM_WAIT;
                    to_cnt_d    = '0;
                end else begin
                    ifid_clr = id_branch_taken;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_d = RUN;
                end else if (to_cnt_q == TO_LAST) begin
                    mem_err = 1'b1;
                    state_d = RUN;
                end else begin
                    pipe_freeze = 1'b1;
                    pc_le       = 1'b0;
                    ifid_le     = 1'b0;
                    to_cnt_d    = to_cnt_q + TO_W'(1);
                end
            end
            default: state_d = RUN;
        endcase

        // Reset overrides everything so the pipeline never sees a stale stall.
        if (Reset) begin
            state_d     = RUN;
            to_cnt_d    = '0;
            pc_le       = 1'b1;
            ifid_le     = 1'b1;
            ifid_clr    = 1'b0;
            nop_sel     = 1'b0;
            pipe_freeze = 1'b0;
            mem_err     = 1'b0;
        end
    end

    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!pipe_freeze) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            ex_d  = '{valid: id_rf_en & ~nop_sel & ~ifid_clr, rd: id_rd, load: id_load};
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_le && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q     <= RUN;
            ex_q        <= SB_EMPTY;
            mem_q       <= SB_EMPTY;
            wb_q        <= SB_EMPTY;
            to_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            to_cnt_q    <= to_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fwd_a     = Reset ? FWD_RF : fwd_a_raw;
    assign fwd_b     = Reset ? FWD_RF : fwd_b_raw;
    assign fwd_c     = Reset ? FWD_RF : fwd_c_raw;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Table-driven bench for pipe_hazard_ctrl: per-cycle stimulus rows with
// expected outputs, pushed to a scoreboard queue and compared mid-cycle.
module tb_pipe_hazard_ctrl;

    localparam int TB_CNT_W   = 5;
    localparam int TB_TIMEOUT = 15;

    logic                clk = 1'b0;
    logic                Reset;
    logic [3:0]          id_rn, id_rm, id_rd;
    logic                id_use_rn, id_use_rm, id_use_rd;
    logic                id_rf_en, id_load, id_branch_taken;
    logic                mem_access, mem_ready;
    logic                pc_le, ifid_le, ifid_clr, nop_sel, pipe_freeze;
    logic [1:0]          fwd_a, fwd_b, fwd_c;
    logic                mem_err;
    logic [TB_CNT_W-1:0] stall_cnt;

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (TB_TIMEOUT),
        .CNT_W       (TB_CNT_W)
    ) dut (
        .clk             (clk),
        .Reset           (Reset),
        .id_rn           (id_rn),
        .id_rm           (id_rm),
        .id_rd           (id_rd),
        .id_use_rn       (id_use_rn),
        .id_use_rm       (id_use_rm),
        .id_use_rd       (id_use_rd),
        .id_rf_en        (id_rf_en),
        .id_load         (id_load),
        .id_branch_taken (id_branch_taken),
        .mem_access      (mem_access),
        .mem_ready       (mem_ready),
        .pc_le           (pc_le),
        .ifid_le         (ifid_le),
        .ifid_clr        (ifid_clr),
        .nop_sel         (nop_sel),
        .pipe_freeze     (pipe_freeze),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .fwd_c           (fwd_c),
        .mem_err         (mem_err),
        .stall_cnt       (stall_cnt)
    );

    always #5 clk = ~clk;

    // ctl = {use_rn, use_rm, use_rd, rf_en, load, branch, mem_access, mem_ready}
    // en  = {pc_le, ifid_le, ifid_clr, nop_sel, pipe_freeze}
    typedef struct {
        string      name;
        logic       rst;
        logic [3:0] rn, rm, rd;
        logic [7:0] ctl;
        logic [4:0] en;
        logic [1:0] fa, fb, fc;
        logic       err;
    } vec_t;

    typedef struct {
        string               name;
        logic [4:0]          en;
        logic [1:0]          fa, fb, fc;
        logic                err;
        logic [TB_CNT_W-1:0] cnt;
    } exp_t;

    vec_t tbl[$];
    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;

    function automatic vec_t mk(string n, logic rst, logic [3:0] rn, logic [3:0] rm,
                                logic [3:0] rd, logic [7:0] ctl, logic [4:0] en,
                                logic [1:0] fa, logic [1:0] fb, logic [1:0] fc, logic err);
        vec_t v;
        v.name = n; v.rst = rst; v.rn = rn; v.rm = rm; v.rd = rd;
        v.ctl = ctl; v.en = en; v.fa = fa; v.fb = fb; v.fc = fc; v.err = err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        Reset           = v.rst;
        id_rn           = v.rn;
        id_rm           = v.rm;
        id_rd           = v.rd;
        {id_use_rn, id_use_rm, id_use_rd, id_rf_en, id_load,
         id_branch_taken, mem_access, mem_ready} = v.ctl;
        e.name = v.name; e.en = v.en; e.fa = v.fa; e.fb = v.fb; e.fc = v.fc;
        e.err = v.err; e.cnt = TB_CNT_W'(exp_cnt);
        sb_q.push_back(e);
        // Counter model: cleared by reset, saturating count of pc_le=0 cycles.
        if (v.rst) exp_cnt = 0;
        else if (!v.en[4] && exp_cnt < (2 ** TB_CNT_W) - 1) exp_cnt++;
        #2;
        e = sb_q.pop_front();
        check({e.name, ".pc_le"},       32'(pc_le),       32'(e.en[4]));
        check({e.name, ".ifid_le"},     32'(ifid_le),     32'(e.en[3]));
        check({e.name, ".ifid_clr"},    32'(ifid_clr),    32'(e.en[2]));
        check({e.name, ".nop_sel"},     32'(nop_sel),     32'(e.en[1]));
        check({e.name, ".pipe_freeze"}, 32'(pipe_freeze), 32'(e.en[0]));
        check({e.name, ".fwd_a"},       32'(fwd_a),       32'(e.fa));
        check({e.name, ".fwd_b"},       32'(fwd_b),       32'(e.fb));
        check({e.name, ".fwd_c"},       32'(fwd_c),       32'(e.fc));
        check({e.name, ".mem_err"},     32'(mem_err),     32'(e.err));
        check({e.name, ".stall_cnt"},   32'(stall_cnt),   32'(e.cnt));
    endtask

    // Memory held busy from a RUN cycle: 15 frozen cycles, then a release with mem_err.
    task automatic push_timeout_episode(input string n);
        for (int k = 0; k <= TB_TIMEOUT; k++) begin
            if (k < TB_TIMEOUT)
                tbl.push_back(mk($sformatf("%s_w%0d", n, k), 0, 0, 0, 0, 8'b0000_0010, 5'b00001, 0, 0, 0, 0));
            else
                tbl.push_back(mk($sformatf("%s_err", n), 0, 0, 0, 0, 8'b0000_0010, 5'b11000, 0, 0, 0, 1));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //                name         rst rn  rm  rd  ctl           en        fa fb fc err
        tbl.push_back(mk("rst_hold",   1,  2,  0,  0,  8'b1001_1110, 5'b11000, 0, 0, 0, 0));
        tbl.push_back(mk("rst_rel",    0,  0,  0,  0,  8'b0000_0000, 5'b11000, 0, 0, 0, 0));
        tbl.push_back(mk("ldr_id",     0,  0,  0,  2,  8'b0001_1000, 5'b11000, 0, 0, 0, 0));
        tbl.push_back(mk("ld_use",     0,  2,  0,  3,  8'b1001_0000, 5'b00010, 1, 0, 0, 0));
        tbl.push_back(mk("ld_fwd",     0,  2,  0,  3,  8'b1001_0000, 5'b11000, 2, 0, 0, 0));
        tbl.push_back(mk("add_r15",    0,  3,  2, 15,  8'b1101_0000, 5'b11000, 1, 3, 0, 0));
        tbl.push_back(mk("add_r5",     0, 15,  3,  5,  8'b1101_0000, 5'b11000, 0, 2, 0, 0));
        tbl.push_back(mk("add_r5b",    0,  5,  3,  5,  8'b1101_0000, 5'b11000, 1, 3, 0, 0));
        tbl.push_back(mk("str_r5",     0, 15,  5,  5,  8'b1110_0000, 5'b11000, 0, 1, 1, 0));
        tbl.push_back(mk("str_mem",    0,  0,  5,  5,  8'b0010_0000, 5'b11000, 0, 0, 2, 0));
        tbl.push_back(mk("br_flush",   0,  0,  0,  0,  8'b0000_0100, 5'b11100, 0, 0, 0, 0));
        tbl.push_back(mk("ldr_r7",     0,  0,  0,  7,  8'b0001_1000, 5'b11000, 0, 0, 0, 0));
        tbl.push_back(mk("br_haz",     0,  0,  7,  0,  8'b0100_0100, 5'b00010, 0, 1, 0, 0));
        tbl.push_back(mk("br_retry",   0,  0,  7,  0,  8'b0100_0100, 5'b11100, 0, 2, 0, 0));
        tbl.push_back(mk("mw1",        0,  7,  0,  0,  8'b1000_0010, 5'b00001, 3, 0, 0, 0));
        tbl.push_back(mk("mw2",        0,  7,  0,  0,  8'b1000_0010, 5'b00001, 3, 0, 0, 0));
        tbl.push_back(mk("mw3",        0,  7,  0,  0,  8'b1000_0010, 5'b00001, 3, 0, 0, 0));
        tbl.push_back(mk("mw_rel",     0,  7,  0,  0,  8'b1000_0011, 5'b11000, 3, 0, 0, 0));
        tbl.push_back(mk("post_rel",   0,  7,  0,  0,  8'b1000_0000, 5'b11000, 0, 0, 0, 0));
        push_timeout_episode("to");
        tbl.push_back(mk("to_after",   0,  0,  0,  0,  8'b0000_0000, 5'b11000, 0, 0, 0, 0));
        tbl.push_back(mk("mw_a",       0,  0,  0,  0,  8'b0000_0010, 5'b00001, 0, 0, 0, 0));
        tbl.push_back(mk("mw_b",       0,  0,  0,  0,  8'b0000_0010, 5'b00001, 0, 0, 0, 0));
        tbl.push_back(mk("rst_mw",     1,  0,  0,  0,  8'b0000_0010, 5'b11000, 0, 0, 0, 0));
        tbl.push_back(mk("post_rst",   0,  0,  0,  0,  8'b0000_0000, 5'b11000, 0, 0, 0, 0));
        for (int e = 0; e < 3; e++) push_timeout_episode($sformatf("sat%0d", e));
        tbl.push_back(mk("sat_end",    0,  0,  0,  0,  8'b0000_0000, 5'b11000, 0, 0, 0, 0));

        Reset = 1'b1;
        {id_rn, id_rm, id_rd} = '0;
        {id_use_rn, id_use_rm, id_use_rd, id_rf_en, id_load,
         id_branch_taken, mem_access, mem_ready} = '0;
        @(posedge clk);

        foreach (tbl[i]) apply(tbl[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
